// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module : pipe_ctrl_pkg
// Brief  : Shared stall vectors, sequencer state encodings and madd phase codes
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    typedef logic [STALL_W-1:0] stall_bus_t;

    // Bit order: pc, IF, ID, EX, MEM, WB (LSB first)
    localparam stall_bus_t StallNone = 6'b000000;
    localparam stall_bus_t StallId   = 6'b000111;
    localparam stall_bus_t StallEx   = 6'b001111;

    typedef enum logic [1:0] {
        CtrlIdle    = 2'd0,
        CtrlMadd2   = 2'd1,
        CtrlDivWait = 2'd2
    } ctrl_state_e;

    localparam logic [1:0] MaddPhase1 = 2'b00;
    localparam logic [1:0] MaddPhase2 = 2'b01;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// Module : pipe_ctrl_if
// Brief  : Request/stall/divider handshake bundle between pipeline and sequencer
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    logic             stallreq_id_i;
    logic             madd_req_i;
    logic             div_req_i;
    logic             div_ready_i;
    logic             flush_i;
    logic             perf_clr_i;
    stall_bus_t       stall_o;
    logic [1:0]       cnt_o;
    logic             div_start_o;
    logic             div_annul_o;
    logic             div_timeout_o;
    logic             busy_o;
    logic [CNT_W-1:0] stall_cycles_o;

    // Pipeline side: raises requests, consumes the stall vector
    modport master (
        output stallreq_id_i, madd_req_i, div_req_i, div_ready_i, flush_i, perf_clr_i,
        input  stall_o, cnt_o, div_start_o, div_annul_o, div_timeout_o, busy_o,
               stall_cycles_o
    );

    // Sequencer side
    modport slave (
        input  stallreq_id_i, madd_req_i, div_req_i, div_ready_i, flush_i, perf_clr_i,
        output stall_o, cnt_o, div_start_o, div_annul_o, div_timeout_o, busy_o,
               stall_cycles_o
    );

endinterface

`default_nettype wire

// File: rtl/pipe_ctrl_sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Saturating up-counter with synchronous clear (clear wins over inc)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc_i,
    input  wire logic             clr_i,
    output logic      [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module : pipe_ctrl
// Brief  : Stall sequencer merging load-use, madd and divide stalls; divide watchdog
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = 40,
    parameter int CNT_W       = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    pipe_ctrl_if.slave bus
);

    localparam logic [7:0] WD_LIMIT = 8'(DIV_TIMEOUT - 1);

    ctrl_state_e state_q, state_d;
    logic [7:0]  wd_q, wd_d;
    logic        wd_clr;
    stall_bus_t  stall;
    logic [1:0]  cnt;
    logic        div_start;
    logic        div_annul;
    logic        div_timeout;

    always_comb begin
        state_d     = state_q;
        wd_clr      = 1'b0;
        stall       = StallNone;
        cnt         = MaddPhase1;
        div_start   = 1'b0;
        div_annul   = 1'b0;
        div_timeout = 1'b0;
        // Gating on rst keeps outputs idle while reset is held, even if EX still requests
        if (rst) begin
            if (bus.flush_i) begin
                state_d   = CtrlIdle;
                wd_clr    = 1'b1;
                div_annul = (state_q == CtrlDivWait) ||
                            ((state_q == CtrlIdle) && bus.div_req_i);
            end else begin
                unique case (state_q)
                    CtrlIdle: begin
                        if (bus.madd_req_i) begin
                            stall   = StallEx;
                            state_d = CtrlMadd2;
                        end else if (bus.div_req_i) begin
                            stall     = StallEx;
                            div_start = 1'b1;
                            wd_clr    = 1'b1;
                            state_d   = CtrlDivWait;
                        end else if (bus.stallreq_id_i) begin
                            stall = StallId;
                        end
                    end
                    CtrlMadd2: begin
                        cnt     = MaddPhase2;
                        state_d = CtrlIdle;
                    end
                    CtrlDivWait: begin
                        stall     = StallEx;
                        div_start = 1'b1;
                        if (bus.div_ready_i) begin
                            stall     = StallNone;
                            div_start = 1'b0;
                            state_d   = CtrlIdle;
                        end else if (wd_q == WD_LIMIT) begin
                            stall       = StallNone;
                            div_start   = 1'b0;
                            div_annul   = 1'b1;
                            div_timeout = 1'b1;
                            state_d     = CtrlIdle;
                        end
                    end
                    default: state_d = CtrlIdle;
                endcase
            end
        end
    end

    always_comb begin
        wd_d = wd_q;
        if (wd_clr) begin
            wd_d = '0;
        end else if (state_q == CtrlDivWait) begin
            wd_d = wd_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CtrlIdle;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stall[0]),
        .clr_i   (bus.perf_clr_i),
        .count_o (bus.stall_cycles_o)
    );

    assign bus.stall_o       = stall;
    assign bus.cnt_o         = cnt;
    assign bus.div_start_o   = div_start;
    assign bus.div_annul_o   = div_annul;
    assign bus.div_timeout_o = div_timeout;
    assign bus.busy_o        = (state_q != CtrlIdle);

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module : tb_pipe_ctrl
// Brief  : Directed self-checking bench for pipe_ctrl (default and short-watchdog builds)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_ctrl_if #(.CNT_W(32)) bus  ();
    pipe_ctrl_if #(.CNT_W(4))  bus2 ();

    pipe_ctrl #(
        .DIV_TIMEOUT (40),
        .CNT_W       (32)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipe_ctrl #(
        .DIV_TIMEOUT (4),
        .CNT_W       (4)
    ) u_dut_wd (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        rst = 1'b0;
        {bus.stallreq_id_i, bus.madd_req_i, bus.div_req_i,
         bus.div_ready_i, bus.flush_i, bus.perf_clr_i} = '0;
        {bus2.stallreq_id_i, bus2.madd_req_i, bus2.div_req_i,
         bus2.div_ready_i, bus2.flush_i, bus2.perf_clr_i} = '0;
        cyc(); cyc();
        check("rst_stall", 32'(bus.stall_o), 32'h00);
        check("rst_busy", 32'(bus.busy_o), 32'h0);
        check("rst_cnt", bus.stall_cycles_o, 32'h0);
        rst = 1'b1;
        cyc();

        // Madd: two EX cycles, stall only in the first
        bus.madd_req_i = 1'b1; #1;
        check("madd1_stall", 32'(bus.stall_o), 32'h0F);
        check("madd1_cnt", 32'(bus.cnt_o), 32'h0);
        cyc(); bus.madd_req_i = 1'b0; #1;
        check("madd2_stall", 32'(bus.stall_o), 32'h00);
        check("madd2_cnt", 32'(bus.cnt_o), 32'h1);
        check("madd2_busy", 32'(bus.busy_o), 32'h1);
        cyc();
        check("madd_done_busy", 32'(bus.busy_o), 32'h0);
        check("madd_perf", bus.stall_cycles_o, 32'd1);

        // Priority: EX request beats load-use; load-use alone
        bus.stallreq_id_i = 1'b1; bus.madd_req_i = 1'b1; #1;
        check("prio_ex_over_id", 32'(bus.stall_o), 32'h0F);
        cyc(); bus.madd_req_i = 1'b0; bus.stallreq_id_i = 1'b0; cyc();
        bus.stallreq_id_i = 1'b1; #1;
        check("id_stall", 32'(bus.stall_o), 32'h07);
        cyc(); bus.stallreq_id_i = 1'b0; #1;
        check("perf_three", bus.stall_cycles_o, 32'd3);

        // madd and div together: madd wins
        bus.madd_req_i = 1'b1; bus.div_req_i = 1'b1; #1;
        check("both_no_start", 32'(bus.div_start_o), 32'h0);
        cyc(); bus.madd_req_i = 1'b0; bus.div_req_i = 1'b0; #1;
        check("both_madd2_cnt", 32'(bus.cnt_o), 32'h1);
        cyc();

        bus.perf_clr_i = 1'b1; cyc(); bus.perf_clr_i = 1'b0; #1;
        check("perf_clr", bus.stall_cycles_o, 32'd0);

        // Divide, ready 33 cycles after start
        bus.div_req_i = 1'b1; #1;
        check("div_t_stall", 32'(bus.stall_o), 32'h0F);
        check("div_t_start", 32'(bus.div_start_o), 32'h1);
        for (int i = 1; i <= 32; i++) begin
            cyc();
            check("div_wait_stall", 32'(bus.stall_o), 32'h0F);
            check("div_wait_start", 32'(bus.div_start_o), 32'h1);
        end
        cyc(); bus.div_ready_i = 1'b1; #1;
        check("div_ready_stall", 32'(bus.stall_o), 32'h00);
        check("div_ready_start", 32'(bus.div_start_o), 32'h0);
        check("div_ready_timeout", 32'(bus.div_timeout_o), 32'h0);
        cyc(); bus.div_ready_i = 1'b0; bus.div_req_i = 1'b0; #1;
        check("div_done_busy", 32'(bus.busy_o), 32'h0);
        check("div_perf33", bus.stall_cycles_o, 32'd33);

        // Flush in the 5th DIV_WAIT cycle
        bus.div_req_i = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        bus.flush_i = 1'b1; #1;
        check("flush_stall", 32'(bus.stall_o), 32'h00);
        check("flush_annul", 32'(bus.div_annul_o), 32'h1);
        check("flush_start", 32'(bus.div_start_o), 32'h0);
        cyc(); bus.flush_i = 1'b0; bus.div_req_i = 1'b0; #1;
        check("flush_busy", 32'(bus.busy_o), 32'h0);
        bus.div_ready_i = 1'b1; #1;
        check("stray_ready_stall", 32'(bus.stall_o), 32'h00);
        cyc(); bus.div_ready_i = 1'b0; #1;
        check("stray_ready_busy", 32'(bus.busy_o), 32'h0);

        // Flush in IDLE with a divide request annuls it
        bus.div_req_i = 1'b1; bus.flush_i = 1'b1; #1;
        check("flush_idle_annul", 32'(bus.div_annul_o), 32'h1);
        check("flush_idle_start", 32'(bus.div_start_o), 32'h0);
        cyc(); bus.flush_i = 1'b0; bus.div_req_i = 1'b0; #1;
        check("flush_idle_busy", 32'(bus.busy_o), 32'h0);

        // Watchdog build (DIV_TIMEOUT=4): pulse in the 4th DIV_WAIT cycle
        bus2.div_req_i = 1'b1; #1;
        check("wd_start", 32'(bus2.div_start_o), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            check("wd_no_pulse", 32'(bus2.div_timeout_o), 32'h0);
        end
        cyc();
        check("wd_timeout", 32'(bus2.div_timeout_o), 32'h1);
        check("wd_annul", 32'(bus2.div_annul_o), 32'h1);
        check("wd_stall", 32'(bus2.stall_o), 32'h00);
        bus2.div_req_i = 1'b0;
        cyc();
        check("wd_idle", 32'(bus2.busy_o), 32'h0);
        check("wd_pulse_gone", 32'(bus2.div_timeout_o), 32'h0);
        check("wd_perf4", 32'(bus2.stall_cycles_o), 32'd4);

        // Saturation of the 4-bit counter, then clear beats a concurrent stall
        bus2.stallreq_id_i = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        check("sat_full", 32'(bus2.stall_cycles_o), 32'hF);
        cyc();
        check("sat_hold", 32'(bus2.stall_cycles_o), 32'hF);
        bus2.perf_clr_i = 1'b1; #1;
        check("clr_with_stall", 32'(bus2.stall_o), 32'h07);
        cyc(); bus2.perf_clr_i = 1'b0; bus2.stallreq_id_i = 1'b0; #1;
        check("clr_wins", 32'(bus2.stall_cycles_o), 32'h0);

        // Asynchronous reset in the middle of a divide
        bus.div_req_i = 1'b1;
        cyc(); cyc();
        check("pre_rst_busy", 32'(bus.busy_o), 32'h1);
        rst = 1'b0; #1;
        check("rst_async_start", 32'(bus.div_start_o), 32'h0);
        check("rst_async_annul", 32'(bus.div_annul_o), 32'h0);
        check("rst_async_busy", 32'(bus.busy_o), 32'h0);
        check("rst_async_perf", bus.stall_cycles_o, 32'h0);
        cyc(); cyc();
        bus.div_req_i = 1'b0;
        rst = 1'b1; #1;
        check("rel_stall", 32'(bus.stall_o), 32'h00);
        check("rel_start", 32'(bus.div_start_o), 32'h0);
        check("rel_busy", 32'(bus.busy_o), 32'h0);
        check("rel_perf", bus.stall_cycles_o, 32'h0);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall sequencer for the five-stage core. It merges the load-use stall request from ID with the multi-cycle HILO operations issued from EX (two-phase madd/msub, iterative divide). It drives one stall vector into pc_reg, if_id, id_ex, ex_mem and mem_wb. It also owns the divider start/annul handshake, a divide watchdog and a saturating stall-cycle performance counter.

## Interface
- DIV_TIMEOUT, 40: DIV_WAIT cycles allowed before the watchdog aborts the divide (valid range 2..255).
- CNT_W, 32: width of the stall-cycle counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- stallreq_id_i  in  1  ID load-use stall request.
- madd_req_i  in  1  EX holds a madd/madddu/msub/msubu.
- div_req_i  in  1  EX holds a div/divu.
- div_ready_i  in  1  divider result valid, single-cycle pulse.
- flush_i  in  1  pipeline flush (branch/exception).
- perf_clr_i  in  1  synchronous clear of the stall counter.
- stall_o  out  6  bit0 pc, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 means hold.
- cnt_o  out  2  madd phase to EX: 00 first phase, 01 second phase.
- div_start_o  out  1  divider start; held high until ready.
- div_annul_o  out  1  divider abort pulse.
- div_timeout_o  out  1  one-cycle watchdog pulse.
- busy_o  out  1  FSM not IDLE.
- stall_cycles_o  out  CNT_W  saturating count of cycles with stall_o[0]=1.

## Operation
- States: IDLE, MADD2, DIV_WAIT. A watchdog counter (8 bit) runs only in DIV_WAIT.
- Stall encodings:
  - EX stall: 6'b001111.
  - ID stall: 6'b000111.
  - No stall: 6'b000000.
- Priority each cycle: flush_i, then FSM/EX request, then stallreq_id_i.
- IDLE:
  - madd_req_i: stall_o=EX stall, cnt_o=00, next MADD2.
  - Else div_req_i: stall_o=EX stall, div_start_o=1, next DIV_WAIT, watchdog cleared.
  - If both madd_req_i and div_req_i are high, madd wins. This is not legal from EX, but the behaviour is defined.
  - Else stallreq_id_i: ID stall.
- MADD2: cnt_o=01, stall_o=0 (EX completes), next IDLE. madd_req_i is ignored in this state.
- DIV_WAIT: stall_o=EX stall, div_start_o=1.
  - div_ready_i: stall_o=0, div_start_o=0, next IDLE.
  - Else, watchdog reaching DIV_TIMEOUT-1: div_annul_o=1, div_timeout_o=1, stall_o=0, next IDLE.
  - stallreq_id_i is masked while EX stall is active.
- div_ready_i is ignored outside DIV_WAIT.
- flush_i, in any state: stall_o=0, cnt_o=00, div_start_o=0, next IDLE, watchdog cleared. div_annul_o=1 if state is DIV_WAIT, or if state is IDLE with div_req_i high.
- stall_cycles_o:
  - +1 on each edge where stall_o[0]=1; saturates at all-ones.
  - perf_clr_i takes priority and loads 0.

## Timing
- All outputs except stall_cycles_o are combinational from state and inputs; state is registered.
- Madd sequence: cycle t cnt=00 with stall, cycle t+1 cnt=01 with no stall. EX occupies 2 cycles.
- Divide: start in cycle t, ready in cycle t+k. Stall is asserted for cycles t..t+k-1 and released in t+k; the EX stage advances at the end of t+k.
- Watchdog: with no ready, the pulse occurs in the DIV_TIMEOUT-th DIV_WAIT cycle.
- Reset (rst=0, asynchronous): state IDLE, watchdog 0, stall_cycles_o 0. Outputs take the IDLE values: stall_o=0, cnt_o=00, div_start_o=0, div_annul_o=0, div_timeout_o=0, busy_o=0. A reset during a divide drops div_start_o immediately, with no annul pulse.
- stall_cycles_o is the registered count; it lags stall_o by one cycle.

## Structure
- Shared define file gains:
  - stall vector constants: StallNone, StallId, StallEx.
  - state encodings: CtrlIdle, CtrlMadd2, CtrlDivWait.
  - StallBus width (6).
  - madd phase codes.
- One sub-module: sat_counter (width parameter, inc, clr, count output), used for stall_cycles_o.
- The watchdog stays inline.

## Test plan
- Reset: hold rst=0 mid-DIV_WAIT, then release -> stall_o=0, div_start_o=0, busy_o=0, stall_cycles_o=0.
- Madd: madd_req_i high for 1 cycle -> stall_o=001111 with cnt_o=00, then stall_o=0 with cnt_o=01, then IDLE.
- Divide: div_req_i, div_ready_i 33 cycles later -> 33 cycles of stall 001111 with div_start_o=1, released on the ready cycle; stall_cycles_o=33.
- Watchdog: DIV_TIMEOUT=4, no ready -> div_annul_o and div_timeout_o pulse in the 4th DIV_WAIT cycle; next state IDLE.
- Flush: flush_i in the 5th DIV_WAIT cycle -> stall_o=0, div_annul_o=1 that cycle, busy_o=0 next cycle. A stray div_ready_i afterwards is ignored.
- Priority/saturation:
  - stallreq_id_i together with madd_req_i -> 001111.
  - stallreq_id_i alone -> 000111.
  - Counter preloaded to all-ones stays there; perf_clr_i together with a stall -> 0.
